uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmit engine (UART_driver) between several on-chip requesters. Each requester offers a 9-bit word through a valid/ready handshake. The scheduler grants one word at a time, launches it with a single-cycle start pulse, and tracks the engine's busy/ready/error signals until the word completes. It then reports completion and the requester ID, and rotates priority.

---
 rtl/uart_sched_pkg.sv | 14 +
 rtl/uart_rr_arbiter.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and default sizing for the UART transmit scheduler.
package uart_sched_pkg;

  localparam int DEFAULT_DATA_W      = 9;
  localparam int DEFAULT_ACK_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } sched_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// ascending with wrap. Produces a one-hot grant and its binary index.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit engine between NUM_REQ requesters: round-robin
// grant, single-cycle launch, busy/error tracking with an acknowledge timeout.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      uart_start,
  output logic [DATA_W-1:0]         uart_data,
  input  logic                      uart_ready,
  input  logic                      uart_busy,
  input  logic                      uart_error,
  output logic                      done_valid,
  output logic [ID_W-1:0]           done_id,
  output logic                      done_err,
  output logic [ID_W-1:0]           grant_id
);

  localparam int              CNT_W    = $clog2(ACK_TIMEOUT);
  // Completion fires on the edge where the count would reach ACK_TIMEOUT-1,
  // putting the done pulse exactly ACK_TIMEOUT cycles after the start pulse.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 2);

  sched_state_t       state, state_next;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;
  logic               sticky_err;

  logic [NUM_REQ-1:0] win_onehot;
  logic [ID_W-1:0]    win_id;
  logic               win_any;

  logic               accept;
  logic               complete;
  logic               complete_err;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (win_onehot),
    .grant_id (win_id),
    .any      (win_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    complete     = 1'b0;
    complete_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (uart_ready && win_any) begin
          accept     = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          complete     = 1'b1;
          complete_err = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          complete     = 1'b1;
          complete_err = sticky_err | uart_error;
        end
      end
      default: state_next = IDLE;
    endcase
    if (complete) state_next = IDLE;
  end

  // req_ready is forced low while reset is held, since the FSM idles in reset.
  assign req_ready  = (rst && accept) ? win_onehot : '0;
  assign uart_start = (state == LAUNCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      cnt        <= '0;
      sticky_err <= 1'b0;
      uart_data  <= '0;
      grant_id   <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_err   <= 1'b0;
    end else begin
      done_valid <= complete;
      if (accept) begin
        uart_data <= req_data[int'(win_id)*DATA_W +: DATA_W];
        grant_id  <= win_id;
      end
      if (state == LAUNCH) begin
        cnt        <= '0;
        sticky_err <= 1'b0;
      end
      if (state == WAIT_BUSY && !uart_busy) cnt <= cnt + 1'b1;
      if (state == WAIT_BUSY || state == WAIT_DONE) sticky_err <= sticky_err | uart_error;
      if (complete) begin
        done_id  <= grant_id;
        done_err <= complete_err;
        ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised bench for uart_tx_scheduler with a queue-of-words requester model,
// a behavioural engine, and a round-robin reference for expected grant order.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 9;
  localparam int TO = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              uart_start;
  logic [DW-1:0]     uart_data;
  logic              uart_ready;
  logic              uart_busy;
  logic              uart_error;
  logic              done_valid;
  logic [IW-1:0]     done_id;
  logic              done_err;
  logic [IW-1:0]     grant_id;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] word [N];
  int            left [N];
  int            model_ptr;

  uart_tx_scheduler #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .uart_busy  (uart_busy),
    .uart_error (uart_error),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_err   (done_err),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = (left[i] > 0);
      req_data[i*DW +: DW]     = word[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) left[i] = 0;
    drive_reqs();
  endtask

  task automatic consume(input int id);
    left[id] = left[id] - 1;
    word[id] = DW'($urandom);
    drive_reqs();
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) begin
      int idx = (model_ptr + k) % N;
      if (left[idx] > 0) return idx;
    end
    return -1;
  endfunction

  task automatic rand_profile(output int d, output int len, output int eoff);
    int mode;
    mode = int'($urandom_range(0, 9));
    if (mode == 0) begin
      d = -1; len = 0; eoff = -1;
    end else begin
      d    = int'($urandom_range(1, TO - 1));
      len  = int'($urandom_range(2, 6));
      eoff = (mode <= 2) ? int'($urandom_range(1, len - 1)) : -1;
    end
  endtask

  // One full transfer. Entered at a sample point with requests already driven.
  // d<0 means the engine never goes busy; eoff>=0 pulses uart_error mid-busy.
  task automatic xfer(input int exp_id, input int d, input int len, input int eoff,
                      input int max_wait, output int waited);
    bit            seen;
    int            act;
    int            exp_k;
    bit            exp_err;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  exp_ready;
    seen   = 0;
    waited = 0;
    for (int i = 0; i <= max_wait; i++) begin
      if (i > 0) begin
        next_cycle();
        #1;
        checks++;
        if (done_valid !== 1'b0) begin
          failures++;
          $display("FAIL done_pulse_width: done_valid=%b required 0", done_valid);
        end
      end
      if (req_ready != '0) begin
        seen   = 1;
        waited = i;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL grant_wait: no req_ready within %0d cycles, expected id %0d", max_wait, exp_id);
      return;
    end
    exp_ready = '0;
    exp_ready[exp_id] = 1'b1;
    checks++;
    if (req_ready !== exp_ready) begin
      failures++;
      $display("FAIL grant_onehot: req_ready=%b required %b", req_ready, exp_ready);
    end
    act = exp_id;
    for (int i = N - 1; i >= 0; i--) if (req_ready[i]) act = i;
    exp_data = word[act];

    next_cycle();
    consume(act);
    uart_busy  = 1'b0;
    uart_error = 1'b0;
    uart_ready = 1'b1;
    #1;
    checks++;
    if (uart_start !== 1'b1 || uart_data !== exp_data || grant_id !== IW'(exp_id)) begin
      failures++;
      $display("FAIL launch: start=%b data=%h grant=%0d required start=1 data=%h grant=%0d",
               uart_start, uart_data, grant_id, exp_data, exp_id);
    end
    checks++;
    if (done_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width: done_valid=%b at launch required 0", done_valid);
    end

    if (d < 0) begin
      exp_k   = TO;
      exp_err = 1'b1;
    end else begin
      exp_k   = d + len + 1;
      exp_err = (eoff >= 0);
    end

    seen = 0;
    for (int k = 1; k <= 200; k++) begin
      next_cycle();
      uart_busy  = (d >= 0) && (k >= d) && (k < d + len);
      uart_error = uart_busy && ((k - d) == eoff);
      uart_ready = !uart_busy;
      #1;
      checks++;
      if (uart_start !== 1'b0 || uart_data !== exp_data) begin
        failures++;
        $display("FAIL hold: cycle %0d start=%b data=%h required start=0 data=%h",
                 k, uart_start, uart_data, exp_data);
      end
      if (done_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (k !== exp_k || done_id !== IW'(exp_id) || done_err !== exp_err) begin
          failures++;
          $display("FAIL done: at +%0d id=%0d err=%b required at +%0d id=%0d err=%b",
                   k, done_id, done_err, exp_k, exp_id, exp_err);
        end
        break;
      end
    end
    uart_error = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_wait: no done_valid within 200 cycles for id %0d", exp_id);
    end
    model_ptr = (exp_id + 1) % N;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({uart_start, uart_data, req_ready, done_valid, done_id, done_err, grant_id} !== '0) begin
      failures++;
      $display("FAIL %s: start=%b data=%h ready=%b dv=%b did=%0d derr=%b gid=%0d required all 0",
               tag, uart_start, uart_data, req_ready, done_valid, done_id, done_err, grant_id);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    uart_ready = 1'b1;
    uart_busy  = 1'b0;
    uart_error = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 1;
      word[i] = DW'($urandom);
    end
    drive_reqs();
    model_ptr = 0;
    #2;
    check_all_zero("reset_state");
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      check_all_zero("reset_hold");
    end
    clear_reqs();
    rst = 1'b1;
  endtask

  task automatic test_contention();
    int w;
    next_cycle();
    for (int i = 0; i < N; i++) begin
      left[i] = 2;
      word[i] = {2'(i), 7'($urandom)};
    end
    drive_reqs();
    #1;
    for (int i = 0; i < 5; i++) xfer(i % N, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), -1,
                                     (i == 0) ? 2 : 0, w);
    clear_reqs();
  endtask

  task automatic test_single();
    int w;
    next_cycle();
    left[2] = 1;
    word[2] = 9'h1A5;
    drive_reqs();
    #1;
    xfer(2, 1, 10, -1, 2, w);
    next_cycle();
    #1;
    checks++;
    if (req_ready !== '0 || done_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after: req_ready=%b done_valid=%b required 0 0", req_ready, done_valid);
    end
    clear_reqs();
  endtask

  task automatic test_timeout();
    int w;
    next_cycle();
    left[1] = 1; word[1] = DW'($urandom);
    left[3] = 1; word[3] = DW'($urandom);
    drive_reqs();
    #1;
    xfer(rr_pick(), -1, 0, -1, 2, w);
    xfer(rr_pick(), 2, 3, -1, 0, w);
    clear_reqs();
  endtask

  task automatic test_engine_error();
    int w;
    next_cycle();
    left[0] = 2;
    word[0] = DW'($urandom);
    drive_reqs();
    #1;
    xfer(0, 2, 5, 2, 2, w);
    xfer(0, 1, 3, -1, 0, w);
    clear_reqs();
  endtask

  task automatic test_back_to_back();
    int w;
    int r;
    r = int'($urandom_range(0, N - 1));
    next_cycle();
    left[r] = 3;
    word[r] = DW'($urandom);
    drive_reqs();
    #1;
    for (int i = 0; i < 3; i++) xfer(r, 1, 1, -1, (i == 0) ? 2 : 0, w);
    clear_reqs();
  endtask

  task automatic test_ready_low();
    int w;
    int cyc;
    next_cycle();
    uart_ready = 1'b0;
    left[0] = 1; word[0] = DW'($urandom);
    left[2] = 1; word[2] = DW'($urandom);
    drive_reqs();
    #1;
    cyc = int'($urandom_range(3, 8));
    for (int i = 0; i < cyc; i++) begin
      checks++;
      if (req_ready !== '0 || uart_start !== 1'b0) begin
        failures++;
        $display("FAIL ready_low: req_ready=%b uart_start=%b required 0 0", req_ready, uart_start);
      end
      next_cycle();
      #1;
    end
    uart_ready = 1'b1;
    #1;
    xfer(rr_pick(), 1, 2, -1, 0, w);
    xfer(rr_pick(), 1, 2, -1, 0, w);
    clear_reqs();
  endtask

  task automatic test_random();
    int w, d, len, eoff, cnt, id;
    next_cycle();
    for (int i = 0; i < N; i++) begin
      left[i] = int'($urandom_range(0, 3));
      word[i] = DW'($urandom);
    end
    left[$urandom_range(0, N - 1)] = 2;
    drive_reqs();
    #1;
    cnt = 0;
    while (rr_pick() >= 0) begin
      id = rr_pick();
      rand_profile(d, len, eoff);
      xfer(id, d, len, eoff, (cnt == 0) ? 2 : 0, w);
      cnt++;
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    int  w;
    bit  seen;
    next_cycle();
    left[2] = 1;
    word[2] = DW'($urandom);
    drive_reqs();
    #1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (req_ready != '0) begin
        seen = 1;
        break;
      end
      next_cycle();
      #1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid_grant: no req_ready before reset test");
    end
    next_cycle();
    consume(2);
    next_cycle();
    uart_busy  = 1'b1;
    uart_ready = 1'b0;
    next_cycle();
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_immediate");
    for (int i = 0; i < N; i++) begin
      left[i] = 1;
      word[i] = DW'($urandom);
    end
    drive_reqs();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      uart_busy  = 1'b0;
      uart_ready = 1'b1;
      #1;
      check_all_zero("reset_mid_hold");
    end
    rst = 1'b1;
    model_ptr = 0;
    #1;
    xfer(0, 1, 2, -1, 0, w);
    clear_reqs();
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_engine_error();
    test_back_to_back();
    test_ready_low();
    test_random();
    test_reset_mid();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
